// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL band-calibration controller.
// Holds the FSM state encoding, the default parameter values and the
// band reset-value helper.
package pll_pkg;

    localparam int unsigned BAND_W_DEF        = 4;
    localparam int unsigned CNT_W_DEF         = 12;
    localparam int unsigned WIN_CYCLES_DEF    = 1024;
    localparam int unsigned SETTLE_CYCLES_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DECIDE,
        ST_TRACK
    } cal_state_e;

    // Mid-scale band code: MSB set, all other bits clear.
    function automatic logic [31:0] band_mid(input int unsigned w);
        band_mid = 32'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/pll_edge_sync.sv
// Brings an asynchronous square wave into the clk domain and emits a
// one-cycle pulse for every rising edge seen after synchronisation.
// Ports:
//   clk     - sampling clock
//   rst     - synchronous reset, active-high
//   async_i - asynchronous input (must toggle slower than clk/2)
//   pulse_o - registered one-cycle pulse per rising edge of async_i
module pll_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic pulse_o
);

    // [0],[1]: two-flop synchroniser; [2]: delayed copy for edge detection
    logic [2:0] sync_q;
    logic       pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], async_i};
            pulse_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pll_band_cal.sv
// VCO band calibration and lock monitor. Picks the band code by
// successive approximation on windowed VCO edge counts, then keeps
// measuring to report lock/unlock, optionally recalibrating.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start             - one-cycle calibration request (ignored while busy)
//   vco_in            - asynchronous VCO (or divided) output
//   target, tol       - desired edge count per window and lock tolerance
//   auto_recal        - recalibrate after two consecutive bad windows
//   band              - VCO band code
//   busy, cal_done    - calibration running / finished
//   lock              - last tracking window within tolerance
//   unlock_sticky     - lock was lost since the last start
//   count_last        - edge count of the most recent completed window
module pll_band_cal
    import pll_pkg::*;
#(
    parameter int unsigned BAND_W        = BAND_W_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned WIN_CYCLES    = WIN_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vco_in,
    input  logic [CNT_W-1:0]  target,
    input  logic [CNT_W-1:0]  tol,
    input  logic              auto_recal,
    output logic [BAND_W-1:0] band,
    output logic              busy,
    output logic              cal_done,
    output logic              lock,
    output logic              unlock_sticky,
    output logic [CNT_W-1:0]  count_last
);

    localparam int unsigned IDX_W   = (BAND_W > 1) ? $clog2(BAND_W) : 1;
    localparam int unsigned TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [BAND_W-1:0] BAND_MID    = BAND_W'(band_mid(BAND_W));
    localparam logic [TMR_W-1:0]  WIN_LAST    = TMR_W'(WIN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    cal_state_e        state_q;
    logic [BAND_W-1:0] band_q;
    logic [IDX_W-1:0]  idx_q;
    logic              busy_q;
    logic              done_q;
    logic              lock_q;
    logic              sticky_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              bad_q;   // previous tracking window was out of tolerance
    logic              eval_q;  // TRACK holds a fresh window to evaluate

    logic              edge_pulse;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [CNT_W:0]    err_c;
    logic              in_tol_c;
    logic              recal_c;
    logic              restart_c;

    pll_edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (vco_in),
        .pulse_o (edge_pulse)
    );

    // Saturating edge count including this cycle's pulse
    assign cnt_inc_c = (edge_pulse && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

    // |count_last - target| one bit wider so it never wraps
    assign err_c    = (count_q >= target) ? ({1'b0, count_q} - {1'b0, target})
                                          : ({1'b0, target} - {1'b0, count_q});
    assign in_tol_c = (err_c <= {1'b0, tol});

    // Second consecutive bad window with auto_recal behaves like start
    assign recal_c   = auto_recal && (state_q == ST_TRACK) && eval_q && !in_tol_c && bad_q;
    // start is honoured whenever no calibration is running (idle or tracking)
    assign restart_c = (start && !busy_q) || recal_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            band_q   <= BAND_MID;
            idx_q    <= IDX_W'(BAND_W - 1);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lock_q   <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            bad_q    <= 1'b0;
            eval_q   <= 1'b0;
        end else if (restart_c) begin
            state_q  <= ST_SETTLE;
            band_q   <= BAND_MID;
            idx_q    <= IDX_W'(BAND_W - 1);
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            lock_q   <= 1'b0;
            sticky_q <= 1'b0;
            tmr_q    <= '0;
            bad_q    <= 1'b0;
            eval_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_SETTLE: begin
                    if (tmr_q == SETTLE_LAST) begin
                        state_q <= ST_MEASURE;
                        tmr_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (tmr_q == WIN_LAST) begin
                        count_q <= cnt_inc_c;
                        tmr_q   <= '0;
                        eval_q  <= !busy_q;
                        state_q <= busy_q ? ST_DECIDE : ST_TRACK;
                    end else begin
                        cnt_q <= cnt_inc_c;
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_DECIDE: begin
                    if (count_q > target) begin
                        band_q[idx_q] <= 1'b0;
                    end
                    if (idx_q != '0) begin
                        band_q[idx_q - IDX_W'(1)] <= 1'b1;
                        idx_q   <= idx_q - IDX_W'(1);
                        state_q <= ST_SETTLE;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        eval_q  <= 1'b0;
                        state_q <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    // First entry after DECIDE has no tracking window yet
                    if (eval_q) begin
                        lock_q <= in_tol_c;
                        bad_q  <= !in_tol_c;
                        if (lock_q && !in_tol_c) begin
                            sticky_q <= 1'b1;
                        end
                    end
                    state_q <= ST_MEASURE;
                    cnt_q   <= '0;
                    tmr_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign band          = band_q;
    assign busy          = busy_q;
    assign cal_done      = done_q;
    assign lock          = lock_q;
    assign unlock_sticky = sticky_q;
    assign count_last    = count_q;

endmodule

// File: tb/tb_pll_band_cal.sv
// Bench for pll_band_cal: a VCO model whose edges per window follow the
// band code, a cycle-scheduled behavioural model of the calibration and
// tracking rules, a per-cycle compare process and directed scenarios.
module tb_pll_band_cal;

    localparam int BW       = 4;
    localparam int CW       = 12;
    localparam int W        = 1024;
    localparam int S        = 64;
    localparam int P        = S + W + 1;   // cycles per SAR step
    localparam int CLK_HALF = 5000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          vco_in = 1'b0;
    logic          vco_fast = 1'b0;
    logic          auto_recal = 1'b0;
    logic [CW-1:0] target = CW'(250);
    logic [CW-1:0] tol = CW'(15);
    logic [BW-1:0] band;
    logic          busy, cal_done, lock, unlock_sticky;
    logic [CW-1:0] count_last;
    logic [BW-1:0] s_band;
    logic          s_busy, s_done, s_lock, s_sticky;
    logic [7:0]    s_count;

    pll_band_cal #(.BAND_W(BW), .CNT_W(CW), .WIN_CYCLES(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .vco_in(vco_in),
        .target(target), .tol(tol), .auto_recal(auto_recal),
        .band(band), .busy(busy), .cal_done(cal_done), .lock(lock),
        .unlock_sticky(unlock_sticky), .count_last(count_last)
    );

    // Narrow-counter instance driven at clk/2 to exercise saturation
    pll_band_cal #(.BAND_W(BW), .CNT_W(8), .WIN_CYCLES(W), .SETTLE_CYCLES(S)) u_sat (
        .clk(clk), .rst(rst), .start(start), .vco_in(vco_fast),
        .target(8'd200), .tol(8'd0), .auto_recal(1'b0),
        .band(s_band), .busy(s_busy), .cal_done(s_done), .lock(s_lock),
        .unlock_sticky(s_sticky), .count_last(s_count)
    );

    initial forever #(CLK_HALF) clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    task automatic check_near(input string name, input int got, input int exp, input int slack);
        int d;
        checks++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > slack) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d exp=%0d+-%0d", name, $time, got, exp, slack);
        end
    endtask

    // VCO model: 0 = 100+20*band+offset edges/window, 1 = fixed count, 2 = stopped
    int vco_mode = 0;
    int vco_fix  = 0;
    int vco_off  = 0;

    function automatic int vco_cnt(input int code);
        if (vco_mode == 2) return 0;
        if (vco_mode == 1) return vco_fix;
        return 100 + 20 * code + vco_off;
    endfunction

    initial begin
        forever begin : gen
            int n;
            if (vco_mode == 2) begin
                vco_in = 1'b0;
                @(posedge clk);
            end else begin
                n = vco_cnt(int'(band));
                if (n < 1) n = 1;
                #(CLK_HALF * W / n) vco_in = ~vco_in;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        vco_fast = ~vco_fast;
    end

    // Behavioural model, advanced once per rising edge from sampled inputs
    int cyc = 0;
    int m_phase = 0;          // 0 idle, 1 calibrating, 2 tracking
    int m_t0 = 0;
    int m_trial[BW];
    int m_final = 0;
    int m_lock = 0;
    int m_sticky = 0;
    int m_bad = 0;
    int m_win_n = 0;
    bit m_armed = 1'b0;
    bit m_cl_chk = 1'b0;
    int m_cl_exp = 0;
    int mk, mr, md;

    function automatic int eval_k(input int j);
        return BW * P + 2 + j * (W + 1) + W;
    endfunction

    // Successive approximation over the VCO model: largest code with count <= target
    function automatic void begin_cal();
        int code;
        int t;
        m_t0     = cyc;
        m_phase  = 1;
        m_lock   = 0;
        m_sticky = 0;
        m_bad    = 0;
        code     = 0;
        for (int i = 0; i < BW; i++) begin
            t = code | (1 << (BW - 1 - i));
            m_trial[i] = t;
            if (vco_cnt(t) <= int'(target)) code = t;
        end
        m_final = code;
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_cl_chk = 1'b0;
        if (rst) begin
            m_phase  = 0;
            m_lock   = 0;
            m_sticky = 0;
            m_armed  = 1'b1;
        end else if (start && m_phase != 1) begin
            begin_cal();
        end else if (m_phase == 1) begin
            mk = cyc - m_t0;
            if (mk == BW * P) begin
                m_phase = 2;
            end else if ((mk % P) == S + W) begin
                m_cl_chk = 1'b1;
                m_cl_exp = vco_cnt(m_trial[mk / P]);
            end
        end else if (m_phase == 2) begin
            mk = cyc - m_t0;
            if (mk >= BW * P + 2) begin
                mr = (mk - (BW * P + 2)) % (W + 1);
                if (mr == W / 2) begin
                    m_win_n = vco_cnt(m_final);
                end else if (mr == W) begin
                    m_cl_chk = 1'b1;
                    m_cl_exp = m_win_n;
                    md = m_win_n - int'(target);
                    if (md < 0) md = -md;
                    if (m_lock == 1 && md > int'(tol)) m_sticky = 1;
                    m_lock = (md <= int'(tol)) ? 1 : 0;
                    m_bad  = m_lock ? 0 : m_bad + 1;
                    if (auto_recal && m_bad >= 2) begin_cal();
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_armed) begin
            case (m_phase)
                0: begin
                    check("band", int'(band), 8);
                    check("busy", int'(busy), 0);
                    check("cal_done", int'(cal_done), 0);
                    check("count_idle", int'(count_last), 0);
                end
                1: begin
                    check("band", int'(band), m_trial[(cyc - m_t0) / P]);
                    check("busy", int'(busy), 1);
                    check("cal_done", int'(cal_done), 0);
                end
                default: begin
                    check("band", int'(band), m_final);
                    check("busy", int'(busy), 0);
                    check("cal_done", int'(cal_done), 1);
                end
            endcase
            check("lock", int'(lock), m_lock);
            check("unlock_sticky", int'(unlock_sticky), m_sticky);
            if (m_phase != 0 && m_cl_chk) check_near("count_last", int'(count_last), m_cl_exp, 2);
        end
    end

    int obs_lat;
    int obs_trial[BW];

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        auto_recal = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_cal(input int tgt, input int tl, input bit au, input bit glitch);
        int k;
        target = CW'(tgt);
        tol = CW'(tl);
        auto_recal = au;
        @(negedge clk);
        start = 1'b1;
        obs_lat = 0;
        for (int i = 0; i < BW; i++) obs_trial[i] = -1;
        do begin
            @(negedge clk);
            obs_lat++;
            start = 1'b0;
            k = obs_lat - 1;
            for (int i = 0; i < BW; i++) if (k == i * P + 1) obs_trial[i] = int'(band);
            if (glitch && (k == S + 100 || k == 2 * P + S + 500)) start = 1'b1;
        end while (!cal_done && obs_lat < 6000);
        start = 1'b0;
        check("cal_finished", int'(cal_done), 1);
    endtask

    task automatic wait_eval(input int j);
        int n;
        n = 0;
        while (!(m_phase == 2 && (cyc - m_t0) == eval_k(j)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("wait_eval_bound", (n < 20000) ? 1 : 0, 1);
    endtask

    task automatic wait_sig(input string name, input bit want_busy, input int limit);
        int n;
        n = 0;
        while (((want_busy && !busy) || (!want_busy && !cal_done)) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < limit) ? 1 : 0, 1);
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and basic calibration to band 7
        do_reset();
        check("rst_band", int'(band), 8);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(cal_done), 0);
        check("rst_lock", int'(lock), 0);
        check("rst_sticky", int'(unlock_sticky), 0);
        check("rst_count", int'(count_last), 0);
        run_cal(250, 15, 1'b0, 1'b0);
        check("latency", obs_lat, 4357);
        check("trial0", obs_trial[0], 8);
        check("trial1", obs_trial[1], 4);
        check("trial2", obs_trial[2], 6);
        check("trial3", obs_trial[3], 7);
        check("band_250", int'(band), 7);
        check("sat_done", int'(s_done), 1);
        check("sat_count", int'(s_count), 255);
        check("sat_band", int'(s_band), 0);

        // Tracking: lock, loss of lock, relock with sticky held
        wait_eval(0);
        check("trk_lock0", int'(lock), 1);
        check_near("trk_count0", int'(count_last), 240, 2);
        check("sat_lock", int'(s_lock), 0);
        check("sat_sticky", int'(s_sticky), 0);
        check("sat_busy", int'(s_busy), 0);
        vco_mode = 1;
        vco_fix = 300;
        wait_eval(1);
        check("trk_lock1", int'(lock), 0);
        check("trk_sticky1", int'(unlock_sticky), 1);
        vco_mode = 0;
        wait_eval(2);
        check("trk_lock2", int'(lock), 1);
        check("trk_sticky2", int'(unlock_sticky), 1);

        // Auto recalibration after two bad windows
        do_reset();
        run_cal(250, 15, 1'b1, 1'b0);
        check("ar_band0", int'(band), 7);
        wait_eval(0);
        check("ar_lock0", int'(lock), 1);
        vco_off = 60;
        wait_eval(1);
        check("ar_lock1", int'(lock), 0);
        wait_sig("ar_busy_seen", 1'b1, 3000);
        check("ar_restart_band", int'(band), 8);
        wait_sig("ar_done_seen", 1'b0, 6000);
        check("ar_band", int'(band), 4);
        vco_off = 0;

        // Boundary targets
        do_reset();
        run_cal(50, 15, 1'b0, 1'b0);
        check("band_t50", int'(band), 0);
        do_reset();
        run_cal(4095, 15, 1'b0, 1'b0);
        check("band_t4095", int'(band), 15);

        // start during MEASURE is ignored
        do_reset();
        run_cal(250, 15, 1'b0, 1'b1);
        check("gl_trial0", obs_trial[0], 8);
        check("gl_trial1", obs_trial[1], 4);
        check("gl_trial2", obs_trial[2], 6);
        check("gl_trial3", obs_trial[3], 7);
        check("gl_band", int'(band), 7);

        // Reset during the second SETTLE
        do_reset();
        target = CW'(250);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (P + 30) @(negedge clk);
        check("pre_rst_band", int'(band), 4);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_band", int'(band), 8);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(cal_done), 0);
        check("mid_rst_lock", int'(lock), 0);
        rst = 1'b0;

        // Stopped VCO: every bit kept, no lock
        do_reset();
        vco_mode = 2;
        run_cal(250, 15, 1'b0, 1'b0);
        check("off_band", int'(band), 15);
        wait_eval(0);
        check("off_count", int'(count_last), 0);
        check("off_lock", int'(lock), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
